pll_reset_seq: RTL and testbench
================================

# pll_reset_seq

Reset sequencer sitting directly downstream of the 12 MHz→16/32 MHz PLL block. Clocked by the PLL's 16 MHz core output, it synchronises the PLL `LOCK` flag, requires it to stay high for a programmable number of cycles, then holds design reset for a further guard interval before releasing the rest of the NTSC pipeline. It re-asserts design reset on any loss of lock and keeps sticky and counted lock-loss status for debug.

## Interface
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synchronised-lock-high cycles required before the guard interval starts; must be ≥1.
- `HOLD_CYCLES`, default 16: guard cycles with reset still asserted after lock is qualified; must be ≥1.
- `clk`  in  1: 16 MHz PLL core clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high; one clock, reset synchronous and active-high.
- `pll_lock`  in  1: raw PLL lock flag, asynchronous to `clk`.
- `sys_reset`  out  1: active-high reset to downstream logic; registered.
- `sys_ready`  out  1: high only in RUN; registered; always `~sys_reset`.
- `lock_lost`  out  1: sticky, set on lock loss while in RUN; cleared only by `reset`.
- `lock_loss_count`  out  8: saturating count of lock-loss events from RUN.

## Operation
- `pll_lock` passes through a 2-flop synchroniser (both flops cleared by `reset`); its output is `lock_s`. No other logic samples `pll_lock`.
- States: WAIT_LOCK, STABLE, HOLD, RUN. Counter widths are `$clog2` of the respective parameter, minimum 1 bit.
- WAIT_LOCK: `lock_s`=1 → STABLE, `scnt`←0.
- STABLE: `lock_s`=0 → WAIT_LOCK. Else if `scnt`==`LOCK_STABLE_CYCLES`-1 → HOLD, `hcnt`←0. Else `scnt`++.
- HOLD: `lock_s`=0 → WAIT_LOCK; no status update. Else if `hcnt`==`HOLD_CYCLES`-1 → RUN. Else `hcnt`++.
- RUN: `lock_s`=0 → WAIT_LOCK, `lock_lost`←1, `lock_loss_count`←min(count+1, 255).
- Outputs are registered. They are updated on the same edge as the state register from next-state: `sys_reset`=(next≠RUN), `sys_ready`=(next==RUN).
- `reset` takes priority over every event.
- `reset` values: state WAIT_LOCK, counters 0, synchroniser 0, `sys_reset`=1, `sys_ready`=0, `lock_lost`=0, `lock_loss_count`=0.
- `reset` asserted mid-sequence in any state forces these values on the next edge. A lock loss coincident with `reset` is not counted.
- A one-cycle `lock_s` drop in STABLE or HOLD restarts qualification from WAIT_LOCK.
- `lock_loss_count` holds at 255; `lock_lost` stays 1 until `reset`.

## Timing
- `pll_lock` rise first sampled at edge k: `lock_s`=1 after edge k+1; STABLE entered at edge k+2; HOLD at edge k+2+N; RUN at edge k+2+N+M, where N=`LOCK_STABLE_CYCLES` and M=`HOLD_CYCLES`.
- `sys_reset` falls and `sys_ready` rises at edge k+N+M+2. Defaults give 1042 cycles, about 65 µs at 16 MHz.
- `pll_lock` fall first sampled at edge j while in RUN: `sys_reset`=1, `sys_ready`=0, `lock_lost`=1 and count increment all occur at edge j+2.
- Re-release after relock follows the same k+N+M+2 rule.
- `sys_reset` and `sys_ready` never glitch and are never both high or both low.

## Test plan
- N=8, M=4; `reset` released, `pll_lock` first sampled high at edge 10 → `sys_reset` 1 through edge 23, falls and `sys_ready` rises at edge 24; `lock_lost`=0, count=0.
- N=8, M=4; lock high from edge 10, low for exactly one sampled cycle at edge 15 → STABLE restarts; release at edge 30 (16+14); `lock_lost` stays 0.
- In RUN, drop `pll_lock` at edge j → `sys_reset`=1 at j+2, `lock_lost`=1, count=1; relock sampled at edge r → release at r+14.
- Repeat RUN→lock-loss→relock 300 times → `lock_loss_count`=255 and holds; `lock_lost`=1.
- Assert `reset` for one cycle while in HOLD with `pll_lock` held high → next edge all outputs at reset values; release occurs 14 cycles after the first post-reset lock sample.
- In RUN, assert `reset` on the same edge that `lock_s` falls → `lock_lost`=0, count=0, `sys_reset`=1.

Source files
------------

// File: rtl/pll_reset_seq.sv
// pll_reset_seq
// Reset sequencer for logic clocked by the PLL core output. It synchronises the
// raw PLL lock flag and requires lock to stay high for LOCK_STABLE_CYCLES cycles.
// It then holds reset for a further HOLD_CYCLES cycles before releasing the
// downstream pipeline. Any loss of lock while running re-asserts reset and is
// recorded in the sticky and counted status outputs.
//
// Ports
//   clk              in   PLL core clock, rising edge
//   reset            in   synchronous active-high reset
//   pll_lock         in   raw PLL lock flag, asynchronous to clk
//   sys_reset        out  active-high downstream reset, registered
//   sys_ready        out  high only while running, registered, ~sys_reset
//   lock_lost        out  sticky flag, set on lock loss while running
//   lock_loss_count  out  saturating count of lock losses while running
//
// state      | meaning
// -----------+----------------------------------------------
// ST_WAIT    | waiting for synchronised lock to go high
// ST_STABLE  | counting consecutive lock-high cycles
// ST_HOLD    | lock qualified, guard interval with reset held
// ST_RUN     | downstream released

module pll_reset_seq #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       sys_reset,
    output logic       sys_ready,
    output logic       lock_lost,
    output logic [7:0] lock_loss_count
);

    localparam int SW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [SW-1:0] SCNT_LAST = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_STABLE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          sys_reset_q, sys_reset_d;
    logic          sys_ready_q, sys_ready_d;
    logic          lock_lost_q, lock_lost_d;
    logic [7:0]    loss_cnt_q, loss_cnt_d;
    logic          lock_s;

    assign lock_s = sync2_q;

    always_comb begin
        sync1_d     = pll_lock;
        sync2_d     = sync1_q;
        state_d     = state_q;
        scnt_d      = scnt_q;
        hcnt_d      = hcnt_q;
        lock_lost_d = lock_lost_q;
        loss_cnt_d  = loss_cnt_q;

        case (state_q)
            ST_WAIT: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                    scnt_d  = '0;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT;
                end else if (scnt_q == SCNT_LAST) begin
                    state_d = ST_HOLD;
                    hcnt_d  = '0;
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    state_d = ST_WAIT;
                end else if (hcnt_q == HCNT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d     = ST_WAIT;
                    lock_lost_d = 1'b1;
                    if (loss_cnt_q != 8'hFF) begin
                        loss_cnt_d = loss_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_WAIT;
        endcase

        // Outputs follow next-state so they change on the same edge as the state.
        sys_reset_d = (state_d != ST_RUN);
        sys_ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_WAIT;
            scnt_q      <= '0;
            hcnt_q      <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sys_reset_q <= 1'b1;
            sys_ready_q <= 1'b0;
            lock_lost_q <= 1'b0;
            loss_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            hcnt_q      <= hcnt_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sys_reset_q <= sys_reset_d;
            sys_ready_q <= sys_ready_d;
            lock_lost_q <= lock_lost_d;
            loss_cnt_q  <= loss_cnt_d;
        end
    end

    assign sys_reset       = sys_reset_q;
    assign sys_ready       = sys_ready_q;
    assign lock_lost       = lock_lost_q;
    assign lock_loss_count = loss_cnt_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
module tb_pll_reset_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       sys_reset;
    logic       sys_ready;
    logic       lock_lost;
    logic [7:0] lock_loss_count;

    int total = 0;
    int bad   = 0;

    pll_reset_seq #(.LOCK_STABLE_CYCLES(8), .HOLD_CYCLES(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .pll_lock        (pll_lock),
        .sys_reset       (sys_reset),
        .sys_ready       (sys_ready),
        .lock_lost       (lock_lost),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       lock;
        logic       e_rst;
        logic       e_rdy;
        logic       e_lost;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Advance one edge and sample #1 after it; outputs must always be complementary.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("exclusive", 0, {7'd0, sys_reset ^ sys_ready}, 8'd1);
    endtask

    task automatic chk_all(input string name, input int idx, input logic er, input logic el, input logic [7:0] ec);
        chk({name, ".sys_reset"}, idx, {7'd0, sys_reset}, {7'd0, er});
        chk({name, ".sys_ready"}, idx, {7'd0, sys_ready}, {7'd0, ~er});
        chk({name, ".lock_lost"}, idx, {7'd0, lock_lost}, {7'd0, el});
        chk({name, ".count"}, idx, lock_loss_count, ec);
    endtask

    task automatic add(input logic r, input logic l, input logic er, input logic el, input logic [7:0] ec);
        vec_t v;
        v.rst = r; v.lock = l; v.e_rst = er; v.e_rdy = ~er; v.e_lost = el; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    initial begin
        int n;
        logic [7:0] exp_cnt;

        reset    = 1'b1;
        pll_lock = 1'b0;
        repeat (3) tick();
        chk_all("reset_vals", 0, 1'b1, 1'b0, 8'd0);

        // Release: lock first sampled at edge 10 -> release at 24.
        // Lock low sampled at edges 30..39 -> reset at 32, relock at 40 -> release at 54.
        for (int e = 1; e <= 60; e++) begin
            add(1'b0, (e >= 10) && !(e >= 30 && e < 40),
                (e < 24) || (e >= 32 && e < 54), (e >= 32), (e >= 32) ? 8'd1 : 8'd0);
        end
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        // One-sample lock glitch at edge 15 restarts qualification -> release at 30.
        for (int e = 1; e <= 32; e++) begin
            add(1'b0, (e >= 10) && (e != 15), (e < 30), 1'b0, 8'd0);
        end

        foreach (vecs[i]) begin
            reset    = vecs[i].rst;
            pll_lock = vecs[i].lock;
            tick();
            chk("vec.sys_reset", i, {7'd0, sys_reset}, {7'd0, vecs[i].e_rst});
            chk("vec.sys_ready", i, {7'd0, sys_ready}, {7'd0, vecs[i].e_rdy});
            chk("vec.lock_lost", i, {7'd0, lock_lost}, {7'd0, vecs[i].e_lost});
            chk("vec.count", i, lock_loss_count, vecs[i].e_cnt);
        end

        // Repeated lock loss from RUN: count saturates at 255, relock takes 15 edges incl. sample edge.
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b0;
            tick();
            tick();
            chk("loss.still_ready", i, {7'd0, sys_ready}, 8'd1);
            tick();
            exp_cnt = (i >= 254) ? 8'd255 : 8'(i + 1);
            chk_all("loss", i, 1'b1, 1'b1, exp_cnt);
            pll_lock = 1'b1;
            n = 0;
            do begin
                tick();
                n++;
            end while (sys_reset && n < 40);
            chk("loss.relock_edges", i, 8'(n), 8'd15);
        end
        chk_all("saturated", 0, 1'b0, 1'b1, 8'd255);

        // Reset during HOLD with lock held high.
        reset    = 1'b1;
        pll_lock = 1'b0;
        tick();
        reset    = 1'b0;
        pll_lock = 1'b1;
        repeat (11) tick();
        chk("hold.pre", 0, {7'd0, sys_reset}, 8'd1);
        reset = 1'b1;
        tick();
        chk_all("hold.reset", 0, 1'b1, 1'b0, 8'd0);
        reset = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (sys_reset && n < 40);
        chk("hold.relock_edges", 0, 8'(n), 8'd15);

        // Reset on the same edge the synchronised lock falls in RUN.
        pll_lock = 1'b0;
        tick();
        tick();
        chk("coinc.pre_ready", 0, {7'd0, sys_ready}, 8'd1);
        reset = 1'b1;
        tick();
        chk_all("coinc", 0, 1'b1, 1'b0, 8'd0);
        reset = 1'b0;
        repeat (4) tick();
        chk_all("coinc.after", 0, 1'b1, 1'b0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
